// File: rtl/fractal_pkg.sv
// Shared definitions for the fractal renderer write path.
//   pixel_t    : pixel word carried from the solvers to the frame buffer
//   waddr_t    : frame-buffer write address
//   ARB_RR     : round-robin grant policy selector
//   ARB_FIXED  : fixed-priority (lowest index wins) grant policy selector
//   next_index : modulo-n increment used by the round-robin search
package fractal_pkg;

  typedef logic [15:0] pixel_t;
  typedef logic [31:0] waddr_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Step an index forward by one, wrapping back to zero at n.
  function automatic int next_index(input int idx, input int n);
    int nxt;
    if (idx + 32'sd1 >= n) begin
      nxt = 32'sd0;
    end else begin
      nxt = idx + 32'sd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/write_fifo.sv
// Synchronous FIFO with a separate occupancy counter.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push, wr_data: write request and word (ignored while full)
//   pop          : read request (ignored while empty)
//   rd_data      : head word, forced to zero while empty
//   full, empty  : occupancy flags
//   count        : number of stored words
module write_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array; contents are never reset because empty gates the head.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Present the head word, or zero when nothing is stored.
  always_comb begin
    rd_data = '0;
    if (!empty) begin
      rd_data = mem_r[rd_ptr_r];
    end else begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/write_arbiter_rr.sv
// Merges pixel writes from NUM_CHANNELS solvers onto one memory write port.
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   in_data/in_addr       : per-channel word and address, held until acked
//   in_valid / in_ack     : per-channel request; in_ack is one-hot or zero
//   out_data/out_addr     : head word of the output FIFO
//   out_channel           : source channel of the head word
//   out_write_en / out_ack: head valid / memory accepted the head
//   fifo_count            : output FIFO occupancy
module write_arbiter_rr
  import fractal_pkg::*;
#(
  parameter int NUM_CHANNELS  = 2,
  parameter int DATA_WIDTH    = $bits(pixel_t),
  parameter int ADDR_WIDTH    = $bits(waddr_t),
  parameter int FIFO_DEPTH    = 4,
  parameter int PRIORITY_MODE = ARB_RR
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] in_addr,
  input  logic [NUM_CHANNELS-1:0]                in_valid,
  output logic [NUM_CHANNELS-1:0]                in_ack,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic [ADDR_WIDTH-1:0]                  out_addr,
  output logic [$clog2(NUM_CHANNELS)-1:0]        out_channel,
  output logic                                   out_write_en,
  input  logic                                   out_ack,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_count
);

  localparam int CH_W    = $clog2(NUM_CHANNELS);
  localparam int ENTRY_W = CH_W + ADDR_WIDTH + DATA_WIDTH;

  logic [CH_W-1:0]    last_grant_r;
  logic [CH_W-1:0]    idx_s;
  logic [CH_W-1:0]    grant_s;
  logic               found_s;
  logic               push_s;
  logic               full_s;
  logic               empty_s;
  logic [ENTRY_W-1:0] wr_entry_s;
  logic [ENTRY_W-1:0] head_s;

  // Scan the channels once, starting after the last winner (round-robin)
  // or at channel 0 (fixed priority); the first valid channel wins.
  always_comb begin
    found_s = 1'b0;
    grant_s = '0;
    if (PRIORITY_MODE == ARB_FIXED) begin
      idx_s = '0;
    end else begin
      idx_s = CH_W'(next_index(int'(last_grant_r), NUM_CHANNELS));
    end
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (!found_s && in_valid[idx_s]) begin
        found_s = 1'b1;
        grant_s = idx_s;
      end else begin
        found_s = found_s;
      end
      idx_s = CH_W'(next_index(int'(idx_s), NUM_CHANNELS));
    end
  end

  // A full FIFO blocks the push even if it pops this cycle, so in_ack
  // never depends on out_ack. Reset holds in_ack low.
  assign push_s = found_s && !full_s && !reset;

  // One-hot acknowledge of the granted channel.
  always_comb begin
    in_ack = '0;
    if (push_s) begin
      in_ack[grant_s] = 1'b1;
    end else begin
      in_ack = '0;
    end
  end

  // The search pointer advances only when a word is actually taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_r <= CH_W'(NUM_CHANNELS - 1);
    end else if (push_s) begin
      last_grant_r <= grant_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign wr_entry_s = {grant_s, in_addr[grant_s], in_data[grant_s]};

  write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_s),
    .wr_data (wr_entry_s),
    .pop     (out_ack),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (fifo_count)
  );

  assign out_data     = head_s[DATA_WIDTH-1:0];
  assign out_addr     = head_s[DATA_WIDTH +: ADDR_WIDTH];
  assign out_channel  = head_s[DATA_WIDTH+ADDR_WIDTH +: CH_W];
  assign out_write_en = !empty_s;

endmodule

// File: tb/tb_write_arbiter_rr.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter (3 channels,
// depth 4) checked against a queue-based reference model.
module tb_write_arbiter_rr;

  localparam int N = 3;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]    ch;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [N-1:0][DW-1:0] rr_data, fx_data;
  logic [N-1:0][AW-1:0] rr_addr, fx_addr;
  logic [N-1:0] rr_valid, fx_valid, rr_in_ack, fx_in_ack;
  logic [DW-1:0] rr_out_data, fx_out_data;
  logic [AW-1:0] rr_out_addr, fx_out_addr;
  logic [1:0] rr_out_channel, fx_out_channel;
  logic rr_wen, fx_wen, rr_oack, fx_oack;
  logic [2:0] rr_count, fx_count;
  logic [56:0] obs_rr, obs_fx;

  assign obs_rr = {rr_in_ack, rr_wen, rr_count, rr_out_channel, rr_out_addr, rr_out_data};
  assign obs_fx = {fx_in_ack, fx_wen, fx_count, fx_out_channel, fx_out_addr, fx_out_data};

  write_arbiter_rr #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                     .FIFO_DEPTH(DEPTH), .PRIORITY_MODE(0)) dut_rr (
    .clock(clock), .reset(reset), .in_data(rr_data), .in_addr(rr_addr),
    .in_valid(rr_valid), .in_ack(rr_in_ack), .out_data(rr_out_data),
    .out_addr(rr_out_addr), .out_channel(rr_out_channel), .out_write_en(rr_wen),
    .out_ack(rr_oack), .fifo_count(rr_count));

  write_arbiter_rr #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                     .FIFO_DEPTH(DEPTH), .PRIORITY_MODE(1)) dut_fx (
    .clock(clock), .reset(reset), .in_data(fx_data), .in_addr(fx_addr),
    .in_valid(fx_valid), .in_ack(fx_in_ack), .out_data(fx_out_data),
    .out_addr(fx_out_addr), .out_channel(fx_out_channel), .out_write_en(fx_wen),
    .out_ack(fx_oack), .fifo_count(fx_count));

  entry_t q_rr[$];
  entry_t q_fx[$];
  int lg_rr;
  int total = 0;
  int bad = 0;

  // Reference grant: -1 when nothing can be taken.
  function automatic int exp_grant(input logic [N-1:0] v, input int lg, input bit fixed, input int occ);
    int c;
    if (occ >= DEPTH) return -1;
    for (int k = 0; k < N; k++) begin
      c = fixed ? k : (lg + 1 + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [56:0] exp_rr();
    entry_t h; int occ; int g; logic [2:0] a;
    occ = q_rr.size(); h = '0;
    if (occ > 0) h = q_rr[0];
    g = exp_grant(rr_valid, lg_rr, 1'b0, occ);
    a = 3'b000;
    if (g >= 0) a = 3'(1 << g);
    return {a, (occ > 0), 3'(occ), h};
  endfunction

  function automatic logic [56:0] exp_fx();
    entry_t h; int occ; int g; logic [2:0] a;
    occ = q_fx.size(); h = '0;
    if (occ > 0) h = q_fx[0];
    g = exp_grant(fx_valid, 0, 1'b1, occ);
    a = 3'b000;
    if (g >= 0) a = 3'(1 << g);
    return {a, (occ > 0), 3'(occ), h};
  endfunction

  // Advance both models across one clock edge using the current inputs.
  task automatic tick();
    int g_rr, g_fx; bit p_rr, p_fx; entry_t e;
    g_rr = exp_grant(rr_valid, lg_rr, 1'b0, q_rr.size());
    g_fx = exp_grant(fx_valid, 0, 1'b1, q_fx.size());
    p_rr = (q_rr.size() > 0) && rr_oack;
    p_fx = (q_fx.size() > 0) && fx_oack;
    @(posedge clock);
    #1;
    if (p_rr) e = q_rr.pop_front();
    if (p_fx) e = q_fx.pop_front();
    if (g_rr >= 0) begin
      e.ch = 2'(g_rr); e.addr = rr_addr[g_rr]; e.data = rr_data[g_rr];
      q_rr.push_back(e);
      lg_rr = g_rr;
      rr_data[g_rr] = 16'($urandom);
    end
    if (g_fx >= 0) begin
      e.ch = 2'(g_fx); e.addr = fx_addr[g_fx]; e.data = fx_data[g_fx];
      q_fx.push_back(e);
      fx_data[g_fx] = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rr_valid = '0; fx_valid = '0; rr_oack = 1'b0; fx_oack = 1'b0;
    #2;
    reset = 1'b0;
    q_rr.delete(); q_fx.delete(); lg_rr = N - 1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rr_addr = {32'h300, 32'h200, 32'h100};
    rr_valid = 3'b011; rr_oack = 1'b0;
    tick(); tick();
    #1;
    total++; if (rr_count !== 3'd2) begin bad++; $display("FAIL reset_prefill got=%0d exp=2", rr_count); end
    #1 reset = 1'b1;
    #1;
    total++; if (obs_rr !== 57'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", obs_rr); end
    rr_valid = 3'b111;
    #1 reset = 1'b0;
    q_rr.delete(); q_fx.delete(); lg_rr = N - 1;
    #1;
    total++; if (rr_in_ack !== 3'b001) begin bad++; $display("FAIL reset_first_grant got=%b exp=001", rr_in_ack); end
    tick();
  endtask

  task automatic test_rr_fairness();
    do_reset();
    rr_addr = {32'h300, 32'h200, 32'h100};
    rr_valid = 3'b111; rr_oack = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      total++; if (rr_in_ack !== 3'(1 << (i % 3))) begin
        bad++; $display("FAIL rr_rotate cyc=%0d got=%b exp=%b", i, rr_in_ack, 3'(1 << (i % 3)));
      end
      total++; if (obs_rr !== exp_rr()) begin bad++; $display("FAIL rr_out cyc=%0d got=%h exp=%h", i, obs_rr, exp_rr()); end
      if (i > 0) begin
        total++; if (rr_wen !== 1'b1 || rr_out_channel !== 2'((i - 1) % 3) || rr_out_addr !== 32'(((i - 1) % 3 + 1) * 256)) begin
          bad++; $display("FAIL rr_out_seq cyc=%0d got=%0d/%h exp=%0d", i, rr_out_channel, rr_out_addr, (i - 1) % 3);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    rr_addr = {32'h300, 32'h200, 32'h100};
    rr_valid = 3'b111; rr_oack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (obs_rr !== exp_rr()) begin bad++; $display("FAIL stall_fill cyc=%0d got=%h exp=%h", i, obs_rr, exp_rr()); end
      tick();
    end
    #1;
    total++; if (rr_count !== 3'd4 || rr_in_ack !== 3'b000) begin
      bad++; $display("FAIL stall_full got=%0d/%b exp=4/000", rr_count, rr_in_ack);
    end
    total++; if (rr_out_channel !== 2'd0 || rr_out_addr !== 32'h100 || rr_out_data !== q_rr[0].data) begin
      bad++; $display("FAIL stall_head got=%0d/%h exp=0/100", rr_out_channel, rr_out_addr);
    end
    rr_oack = 1'b1;
    #1;
    total++; if (obs_rr !== exp_rr()) begin bad++; $display("FAIL stall_pop got=%h exp=%h", obs_rr, exp_rr()); end
    tick();
    rr_oack = 1'b0;
    #1;
    total++; if (rr_count !== 3'd3 || rr_in_ack !== 3'b010) begin
      bad++; $display("FAIL stall_after_pop got=%0d/%b exp=3/010", rr_count, rr_in_ack);
    end
    tick();
    #1;
    total++; if (rr_count !== 3'd4) begin bad++; $display("FAIL stall_refill got=%0d exp=4", rr_count); end
    total++; if (obs_rr !== exp_rr()) begin bad++; $display("FAIL stall_refill_out got=%h exp=%h", obs_rr, exp_rr()); end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    fx_addr = {32'h300, 32'h200, 32'h100};
    fx_valid = 3'b101; fx_oack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (fx_in_ack !== 3'b001) begin bad++; $display("FAIL fx_low_wins cyc=%0d got=%b exp=001", i, fx_in_ack); end
      total++; if (obs_fx !== exp_fx()) begin bad++; $display("FAIL fx_out cyc=%0d got=%h exp=%h", i, obs_fx, exp_fx()); end
      tick();
    end
    fx_valid = 3'b100;
    #1;
    total++; if (fx_in_ack !== 3'b100) begin bad++; $display("FAIL fx_drop0 got=%b exp=100", fx_in_ack); end
    tick();
    fx_valid = 3'b000;
    #1;
    total++; if (obs_fx !== exp_fx() || fx_out_channel !== 2'd2) begin
      bad++; $display("FAIL fx_ch2_out got=%h exp=%h", obs_fx, exp_fx());
    end
    tick();
  endtask

  task automatic test_single_stream();
    do_reset();
    rr_addr = {32'h3000, 32'h2000, 32'h1000};
    rr_valid = 3'b010; rr_oack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++; if (rr_in_ack !== 3'b010 || rr_count > 3'd1) begin
        bad++; $display("FAIL stream_ack cyc=%0d got=%b/%0d exp=010/<=1", i, rr_in_ack, rr_count);
      end
      total++; if (obs_rr !== exp_rr()) begin bad++; $display("FAIL stream_out cyc=%0d got=%h exp=%h", i, obs_rr, exp_rr()); end
      rr_addr[1] = rr_addr[1] + 32'd4;
      tick();
    end
    rr_valid = 3'b000;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (obs_rr !== exp_rr()) begin bad++; $display("FAIL stream_drain cyc=%0d got=%h exp=%h", i, obs_rr, exp_rr()); end
      tick();
    end
  endtask

  task automatic test_sparse();
    do_reset();
    rr_addr = {32'h0000_0ABC, 32'h0, 32'h0};
    rr_valid = 3'b100; rr_oack = 1'b1;
    #1;
    total++; if (rr_in_ack !== 3'b100 || rr_wen !== 1'b0) begin
      bad++; $display("FAIL sparse_ack got=%b/%b exp=100/0", rr_in_ack, rr_wen);
    end
    tick();
    rr_valid = 3'b000;
    #1;
    total++; if (rr_wen !== 1'b1 || rr_out_channel !== 2'd2 || rr_out_addr !== 32'h0000_0ABC) begin
      bad++; $display("FAIL sparse_present got=%b/%0d/%h exp=1/2/abc", rr_wen, rr_out_channel, rr_out_addr);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (rr_wen !== 1'b0 || rr_count !== 3'd0) begin
        bad++; $display("FAIL sparse_idle cyc=%0d got=%b/%0d exp=0/0", i, rr_wen, rr_count);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a_rr, a_fx;
    do_reset();
    for (int c = 0; c < N; c++) begin
      rr_addr[c] = $urandom; fx_addr[c] = $urandom;
    end
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        if (!rr_valid[c]) begin
          rr_valid[c] = ($urandom_range(0, 2) != 0);
          rr_addr[c] = $urandom; rr_data[c] = 16'($urandom);
        end
        if (!fx_valid[c]) begin
          fx_valid[c] = ($urandom_range(0, 2) != 0);
          fx_addr[c] = $urandom; fx_data[c] = 16'($urandom);
        end
      end
      rr_oack = ($urandom_range(0, 3) != 0);
      fx_oack = ($urandom_range(0, 1) != 0);
      #1;
      total++; if (obs_rr !== exp_rr()) begin bad++; $display("FAIL rand_rr cyc=%0d got=%h exp=%h", i, obs_rr, exp_rr()); end
      total++; if (obs_fx !== exp_fx()) begin bad++; $display("FAIL rand_fx cyc=%0d got=%h exp=%h", i, obs_fx, exp_fx()); end
      a_rr = rr_in_ack; a_fx = fx_in_ack;
      tick();
      // An acknowledged channel is free to drop or present a new word.
      rr_valid = rr_valid & ~a_rr;
      fx_valid = fx_valid & ~a_fx;
    end
  endtask

  initial begin
    reset = 1'b1;
    rr_data = '0; fx_data = '0; rr_addr = '0; fx_addr = '0;
    test_reset();
    test_rr_fairness();
    test_stall();
    test_fixed_priority();
    test_single_stream();
    test_sparse();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/write_arbiter_rr.md
# write_arbiter_rr

Parametrised successor to the solver write arbitration stage. It merges pixel writes from `NUM_CHANNELS` tile solvers onto one memory write port. It adds a selectable round-robin or fixed-priority grant policy, an output FIFO that keeps solvers draining while memory stalls, and source-channel tagging. It sits between the solver array's `out_addr/out_data/out_valid/out_ready` ports and the frame-buffer write master.

## Interface
- `NUM_CHANNELS`, 2: number of solver inputs; range ≥2.
- `DATA_WIDTH`, 16: pixel word width.
- `ADDR_WIDTH`, 32: write address width.
- `FIFO_DEPTH`, 4: output FIFO entries; must be a power of two, ≥2.
- `PRIORITY_MODE`, 0: 0 = round-robin, 1 = fixed priority with lowest index winning.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_data`  in  [NUM_CHANNELS][DATA_WIDTH]  per-channel pixel word.
- `in_addr`  in  [NUM_CHANNELS][ADDR_WIDTH]  per-channel write address.
- `in_valid`  in  [NUM_CHANNELS]  channel holds a word.
- `in_ack`  out  [NUM_CHANNELS]  combinational, one-hot or zero; the word transfers on `in_valid[i] && in_ack[i]`.
- `out_data`  out  DATA_WIDTH  FIFO head data.
- `out_addr`  out  ADDR_WIDTH  FIFO head address.
- `out_channel`  out  $clog2(NUM_CHANNELS)  source channel of the head word.
- `out_write_en`  out  1  the head word is valid (FIFO not empty).
- `out_ack`  in  1  memory accepted the head word this cycle.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  occupancy.

## Operation
- **Push condition:** `full = (fifo_count == FIFO_DEPTH)`. When `!full` and any `in_valid` is high, exactly one channel `g` is granted. `in_ack[g]=1`, and {in_data[g], in_addr[g], g} is written at the clock edge.
- **Push while full:** no push occurs, even if a pop happens in the same cycle. This is a deliberate simplification that keeps `in_ack` independent of `out_ack`.
- **Round-robin policy:** register `last_grant` resets to `NUM_CHANNELS-1`. The search starts at `last_grant+1` and wraps modulo `NUM_CHANNELS`. The first valid channel found wins. `last_grant` updates only on a push.
- **Fixed-priority policy:** the lowest-index valid channel wins. `last_grant` is unused.
- **Input stability:** solvers hold `in_valid`, `in_data` and `in_addr` stable until acked. The arbiter does not latch unacked inputs.
- **Output handshake:** `out_write_en = !empty`. Head fields are stable while `out_write_en && !out_ack`. A pop occurs on `out_write_en && out_ack`, and the next entry appears the following cycle.
- **Simultaneous push and pop (not full):** occupancy is unchanged and ordering is preserved.
- **FIFO mechanics:** read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Occupancy is held in a separate counter.
- **`out_ack` while empty:** ignored.

## Timing
- **Reset values:** `in_ack=0`, `out_write_en=0`, `out_data=0`, `out_addr=0`, `out_channel=0`, `fifo_count=0`, pointers 0, `last_grant=NUM_CHANNELS-1`.
- **Latency:** a word pushed at edge t is presented with `out_write_en=1` in cycle t+1 if the FIFO was empty.
- **Throughput:** one push and one pop per cycle are sustained.
- **`in_ack` timing:** combinational from `in_valid`, `fifo_count` and `last_grant`. There is no path from `out_ack` to `in_ack`.
- **Reset mid-operation:** the asynchronous assert immediately clears all outputs. Queued words are discarded, because solvers are reset on the same signal.

## Structure
- **Shared package `fractal_pkg`:** typedefs `pixel_t` (16b) and `waddr_t` (32b), plus the `ARB_RR` and `ARB_FIXED` constants for `PRIORITY_MODE`.
- **Sub-module `write_fifo`:** parametrised synchronous FIFO (width, depth) with `push`, `pop`, `full`, `empty` and `count`. The arbiter owns only the grant logic and `last_grant`.

## Test plan
- **Reset:** assert `reset` mid-cycle with the FIFO holding 2 words -> all outputs read 0 immediately and `fifo_count=0`; after release the first grant goes to channel 0.
- **Round-robin fairness:** `NUM_CHANNELS=3`, `PRIORITY_MODE=0`, all `in_valid=1`, `out_ack=1`, addrs 0x100/0x200/0x300 -> acks rotate 0,1,2,0,1,2; the output sequence matches with `out_channel` 0,1,2,…
- **Memory stall:** `out_ack=0` with all channels valid -> exactly 4 pushes, then `in_ack=0`, `fifo_count=4` and the head is stable. Raising `out_ack` for 1 cycle -> one pop, `fifo_count=3`, one push the next cycle.
- **Fixed priority:** `PRIORITY_MODE=1`, channels 0 and 2 continuously valid, `out_ack=1` -> channel 0 is acked every cycle and channel 2 is never acked; dropping channel 0 -> channel 2 is acked the same cycle.
- **Single-channel streaming:** channel 1 only, 8 back-to-back words, `out_ack=1` -> `in_ack[1]` is high every cycle, each word appears 1 cycle later, order is preserved and `fifo_count` stays ≤1.
- **Sparse input:** one word while empty with `out_ack=1` -> `out_write_en` is high for exactly one cycle, then returns to 0.
